// File: rtl/uart_tx_arbiter_if.sv
// Bus between up to four transmit requesters, the arbiter and the UART.
// master drives requests/config, slave (the arbiter) returns grant/UART drive.
interface uart_tx_arbiter_if;
  logic [15:0] divisor;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  grant;
  logic        busy;
  logic        send;
  logic [7:0]  tx_data;

  modport master (output divisor, req, data_in, input grant, busy, send, tx_data);
  modport slave  (input divisor, req, data_in, output grant, busy, send, tx_data);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: picks one of four requesters, hands its byte to the UART,
// holds send for 2 baud ticks, then waits 10 more ticks (one UART frame)
// before accepting the next request.
// Build option: define FIXED_PRIORITY_EN for fixed priority (req[0] highest);
// default build is round-robin starting after the last granted requester.
module uart_tx_arbiter (
  input  logic              sysclk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [15:0] div_q;
  logic [15:0] div_eff;
  logic [3:0]  tick_cnt;
  logic        tick;
  logic        any_req;
  logic [1:0]  winner;
  logic [3:0]  grant_c;
  logic [7:0]  tx_q;
`ifndef FIXED_PRIORITY_EN
  logic [1:0]  last;
  logic [1:0]  idx;
`endif

  // divisor 0 behaves as 1; the active period is re-sampled at every reload
  assign div_eff = (bus.divisor == 16'd0) ? 16'd1 : bus.divisor;
  assign tick    = (state != IDLE) && (cnt == div_q - 16'd1);
  assign any_req = |bus.req;

  // winner selection
  always_comb begin
    winner = 2'd0;
`ifdef FIXED_PRIORITY_EN
    for (int i = 3; i >= 0; i--)
      if (bus.req[i]) winner = 2'(i);
`else
    // walk from farthest to nearest so the nearest after last wins
    idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (bus.req[idx]) winner = idx;
    end
`endif
  end

  // state register
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = SEND;
      SEND: if (tick && tick_cnt == 4'd1) state_nxt = HOLD;
      HOLD: if (tick && tick_cnt == 4'd9) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // one-cycle grant in the accepting IDLE cycle; suppressed while in reset
  always_comb begin
    grant_c = 4'b0000;
    if (state == IDLE && any_req && !reset) grant_c[winner] = 1'b1;
  end

  // baud tick divider: idle clears it, otherwise reloads on each tick
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt   <= 16'd0;
      div_q <= 16'd1;
    end else if (state == IDLE) begin
      cnt   <= 16'd0;
      div_q <= div_eff;
    end else if (tick) begin
      cnt   <= 16'd0;
      div_q <= div_eff;
    end else begin
      cnt   <= cnt + 16'd1;
    end
  end

  // ticks spent in the current SEND/HOLD phase
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)                   tick_cnt <= 4'd0;
    else if (state == IDLE)      tick_cnt <= 4'd0;
    else if (tick) begin
      if (state_nxt != state)    tick_cnt <= 4'd0;
      else                       tick_cnt <= tick_cnt + 4'd1;
    end
  end

  // capture the winner's byte (and, for round-robin, who won) on acceptance
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tx_q <= 8'h00;
`ifndef FIXED_PRIORITY_EN
      last <= 2'd3;
`endif
    end else if (state == IDLE && any_req) begin
      tx_q <= bus.data_in[{winner, 3'b000} +: 8];
`ifndef FIXED_PRIORITY_EN
      last <= winner;
`endif
    end
  end

  assign bus.grant   = grant_c;
  assign bus.busy    = (state != IDLE);
  assign bus.send    = (state == SEND);
  assign bus.tx_data = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand sequences for
// round-robin/priority, reset abort, plus randomized run against a
// transfer-length reference model.
module tb_uart_tx_arbiter;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  int   tests  = 0;
  int   fails  = 0;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [15:0] div;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  g;
    logic [7:0]  tx;
    int          send_n;
    int          busy_n;
  } vec_t;

  vec_t vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.req     = 4'b0000;
    bus.data_in = 32'h0;
    repeat (2) @(posedge sysclk);
    #1 reset = 1'b0;
  endtask

  // reference arbitration from the rules, not from the RTL structure
  function automatic int pick(input logic [3:0] r, input int last);
`ifdef FIXED_PRIORITY_EN
    for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
`endif
    return -1;
  endfunction

  // collect n grants with req held, check values and 25-cycle spacing (div=2)
  task automatic grant_run(input string name, input logic [3:0] r, input int n,
                           input logic [3:0] exp0, input logic [3:0] exp1,
                           input logic [3:0] exp2, input logic [3:0] exp3,
                           input logic [3:0] exp4);
    logic [3:0] expv [5];
    logic [3:0] got  [5];
    int         at   [5];
    int         ng = 0;
    expv[0] = exp0; expv[1] = exp1; expv[2] = exp2; expv[3] = exp3; expv[4] = exp4;
    do_reset();
    bus.divisor = 16'd2;
    bus.req     = r;
    for (int c = 0; c < 400 && ng < n; c++) begin
      @(negedge sysclk);
      if (bus.grant != 4'b0000) begin
        got[ng] = bus.grant;
        at[ng]  = c;
        ng++;
      end
    end
    check({name, " count"}, ng, n);
    for (int i = 0; i < ng; i++) begin
      check($sformatf("%s grant%0d", name, i), got[i], expv[i]);
      if (i > 0) check($sformatf("%s gap%0d", name, i), at[i] - at[i-1], 25);
    end
    bus.req = 4'b0000;
  endtask

  int         rem, dcur, mlast, win, dd;
  logic [7:0] mtx;
  logic [3:0] eg;

  initial begin
    bus.divisor = 16'd4;
    bus.req     = 4'b1111;
    bus.data_in = 32'hFFFF_FFFF;

    // ---- reset state, with all requests active during reset
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    check("rst grant", bus.grant, 4'b0000);
    check("rst busy", bus.busy, 1'b0);
    check("rst send", bus.send, 1'b0);
    check("rst tx", bus.tx_data, 8'h00);
    bus.req = 4'b0000;
    @(posedge sysclk);
    #1 reset = 1'b0;

    // ---- vector table (expected grants assume fresh reset before v0)
    vt[0] = '{16'd4, 4'b0001, 32'h0000_00A5, 4'b0001, 8'hA5, 8,  48};
    vt[1] = '{16'd0, 4'b0001, 32'hDEAD_BE3C, 4'b0001, 8'h3C, 2,  12};
`ifdef FIXED_PRIORITY_EN
    vt[2] = '{16'd1, 4'b1001, 32'h7766_5544, 4'b0001, 8'h44, 2,  12};
`else
    vt[2] = '{16'd1, 4'b1001, 32'h7766_5544, 4'b1000, 8'h77, 2,  12};
`endif
    vt[3] = '{16'd3, 4'b1001, 32'h8899_AABB, 4'b0001, 8'hBB, 6,  36};
    vt[4] = '{16'd2, 4'b0110, 32'h1234_5678, 4'b0010, 8'h56, 4,  24};
`ifdef FIXED_PRIORITY_EN
    vt[5] = '{16'd5, 4'b0110, 32'hCAFE_F00D, 4'b0010, 8'hF0, 10, 60};
`else
    vt[5] = '{16'd5, 4'b0110, 32'hCAFE_F00D, 4'b0100, 8'hFE, 10, 60};
`endif

    for (int v = 0; v < 6; v++) begin
      int sn, bn;
      bit tx_ok, g_ok, s_ok;
      sn = 0; bn = 0; tx_ok = 1; g_ok = 1; s_ok = 1;
      @(posedge sysclk); #1;
      bus.divisor = vt[v].div;
      bus.req     = vt[v].req;
      bus.data_in = vt[v].data;
      @(negedge sysclk);
      check($sformatf("v%0d grant", v), bus.grant, vt[v].g);
      @(posedge sysclk); #1;
      bus.req     = 4'b0000;
      bus.data_in = $urandom;
      for (int c = 0; c < 2000; c++) begin
        @(negedge sysclk);
        if (bus.tx_data !== vt[v].tx) tx_ok = 0;
        if (!bus.busy) break;
        bn++;
        if (bus.send) sn++;
        if (bus.send !== (bn <= vt[v].send_n)) s_ok = 0;
        if (bus.grant !== 4'b0000) g_ok = 0;
        @(posedge sysclk); #1;
        if (c % 5 == 2) bus.data_in = $urandom;
      end
      check($sformatf("v%0d tx stable", v), tx_ok, 1'b1);
      check($sformatf("v%0d grant quiet", v), g_ok, 1'b1);
      check($sformatf("v%0d send shape", v), s_ok, 1'b1);
      check($sformatf("v%0d send cycles", v), sn, vt[v].send_n);
      check($sformatf("v%0d busy cycles", v), bn, vt[v].busy_n);
    end

    // ---- held requests: rotation / priority
`ifdef FIXED_PRIORITY_EN
    grant_run("all", 4'b1111, 5, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
`else
    grant_run("all", 4'b1111, 5, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001);
`endif
`ifdef FIXED_PRIORITY_EN
    grant_run("pair", 4'b1010, 4, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
`else
    grant_run("pair", 4'b1010, 4, 4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0000);
`endif

    // ---- reset 5 cycles into SEND aborts the transfer
    do_reset();
    bus.divisor = 16'd4;
    bus.req     = 4'b0100;
    bus.data_in = 32'h005A_0000;
    @(negedge sysclk);
    check("abort grant", bus.grant, 4'b0100);
    @(posedge sysclk); #1;
    bus.req = 4'b0000;
    repeat (5) @(posedge sysclk);
    #2;
    check("abort pre send", bus.send, 1'b1);
    reset   = 1'b1;
    bus.req = 4'b0011;
    bus.data_in = 32'h0000_00C7;
    #1;
    check("abort send", bus.send, 1'b0);
    check("abort busy", bus.busy, 1'b0);
    check("abort grant0", bus.grant, 4'b0000);
    check("abort tx", bus.tx_data, 8'h00);
    @(posedge sysclk); #1;
    reset = 1'b0;
    @(negedge sysclk);
    check("resume grant", bus.grant, 4'b0001);
    @(posedge sysclk); #1;
    bus.req = 4'b0000;
    check("resume tx", bus.tx_data, 8'hC7);
    check("resume busy", bus.busy, 1'b1);

    // ---- randomized run against the reference model
    do_reset();
    rem = 0; dcur = 1; mlast = 3; mtx = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if (rem == 0 && $urandom_range(0, 3) == 0) bus.divisor = 16'($urandom_range(0, 3));
      bus.req     = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      bus.data_in = $urandom;
      @(negedge sysclk);
      eg  = 4'b0000;
      win = -1;
      if (rem == 0) begin
        win = pick(bus.req, mlast);
        if (win >= 0) eg[win] = 1'b1;
      end
      check("rnd grant", bus.grant, eg);
      check("rnd busy", bus.busy, rem > 0);
      check("rnd send", bus.send, rem > 10 * dcur);
      check("rnd tx", bus.tx_data, mtx);
      if (rem > 0) rem--;
      else if (win >= 0) begin
        dd    = (bus.divisor == 16'd0) ? 1 : int'(bus.divisor);
        dcur  = dd;
        rem   = 12 * dd;
        mtx   = bus.data_in[8*win +: 8];
        mlast = win;
      end
      @(posedge sysclk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
